// File: rtl/writeback_stage.sv
// writeback_stage -- final pipeline stage, directly downstream of the memory stage.
//
// Commits up to two register-file writes per instruction: the primary destination
// and the special destination (e.g. RDX of MUL/DIV). When the destination is memory,
// the stage first performs a store over a dedicated D-cache write port. The port
// sends an address beat, then a data beat, then waits for a completion.
// While the store is outstanding, wbStallOut holds the memory stage. The
// instruction retires once the store has completed.
//
// Ports:
//   clk, reset                   stage clock (shared with the D-cache bus), sync active-high reset
//   validIn                      instruction valid (opcodeValid AND isMemorySuccessful)
//   currentRipIn, opcodeIn       RIP and primary opcode of the instruction
//   destReg*In                   primary destination index / valid / value (value is also store data)
//   destRegSpecial*In            special destination index / valid / value
//   isMemoryAccessDestIn         destination is memory (store)
//   memoryAddressDestIn          store address
//   wbStallOut                   combinational hold back to the memory stage
//   rfWrEn/rfWrAddr/rfWrData     primary register-file write port
//   rfWr2En/rfWr2Addr/rfWr2Data  special register-file write port (applied last by the RF)
//   retireOut, retireRipOut      one-cycle commit pulse and its RIP
//   stReqCyc/stReq/stReqTag      store request valid / beat payload / tag {write, mem, opcode}
//   stReqAck                     beat accepted
//   stRespCyc, stRespAck         store completion and its one-cycle acknowledge
//
// Optional build macro WB_TRACE_EN: adds a retired-instruction counter and prints
// RETIRE / STORE trace lines. Ports and timing are the same with or without it.

module writeback_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int REG_W  = 4,
  parameter int TAG_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validIn,
  input  logic [63:0]       currentRipIn,
  input  logic [7:0]        opcodeIn,
  input  logic [REG_W-1:0]  destRegIn,
  input  logic              destRegValidIn,
  input  logic [DATA_W-1:0] destRegValueIn,
  input  logic [REG_W-1:0]  destRegSpecialIn,
  input  logic              destRegSpecialValidIn,
  input  logic [DATA_W-1:0] destRegSpecialValueIn,
  input  logic              isMemoryAccessDestIn,
  input  logic [ADDR_W-1:0] memoryAddressDestIn,
  output logic              wbStallOut,
  output logic              rfWrEn,
  output logic [REG_W-1:0]  rfWrAddr,
  output logic [DATA_W-1:0] rfWrData,
  output logic              rfWr2En,
  output logic [REG_W-1:0]  rfWr2Addr,
  output logic [DATA_W-1:0] rfWr2Data,
  output logic              retireOut,
  output logic [63:0]       retireRipOut,
  output logic              stReqCyc,
  output logic [63:0]       stReq,
  output logic [TAG_W-1:0]  stReqTag,
  input  logic              stReqAck,
  input  logic              stRespCyc,
  output logic              stRespAck
);

  typedef enum logic [1:0] {IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

  state_t            state, state_next;
  logic              store_done;
  logic              store_start;
  logic              accept;

  logic              st_req_cyc_d;
  logic [63:0]       st_req_d;
  logic [TAG_W-1:0]  st_req_tag_d;
  logic              st_resp_ack_d;

  // A store that has not completed yet keeps the instruction parked here.
  assign store_start = validIn && isMemoryAccessDestIn && !store_done;
  assign wbStallOut  = (state != IDLE) || store_start;
  assign accept      = validIn && !wbStallOut;

  // State register, together with the registered store-bus outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      stReqCyc  <= 1'b0;
      stReq     <= '0;
      stReqTag  <= '0;
      stRespAck <= 1'b0;
    end else begin
      state     <= state_next;
      stReqCyc  <= st_req_cyc_d;
      stReq     <= st_req_d;
      stReqTag  <= st_req_tag_d;
      stRespAck <= st_resp_ack_d;
    end
  end

  // Next-state logic. Acks outside the states that wait for them are ignored,
  // and a completion coinciding with the data-beat ack is not sampled.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (store_start) state_next = ST_ADDR;
      ST_ADDR: if (stReqAck)    state_next = ST_DATA;
      ST_DATA: if (stReqAck)    state_next = ST_RESP;
      ST_RESP: if (stRespCyc)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Output logic: next values of the store-bus registers.
  always_comb begin
    st_req_cyc_d  = stReqCyc;
    st_req_d      = stReq;
    st_req_tag_d  = stReqTag;
    st_resp_ack_d = 1'b0;
    unique case (state)
      IDLE: if (store_start) begin
        st_req_cyc_d = 1'b1;
        st_req_d     = memoryAddressDestIn;
        st_req_tag_d = {1'b1, 1'b1, opcodeIn};
      end
      ST_ADDR: if (stReqAck) st_req_d = destRegValueIn;
      ST_DATA: if (stReqAck) st_req_cyc_d = 1'b0;
      ST_RESP: if (stRespCyc) st_resp_ack_d = 1'b1;
      default: st_req_cyc_d = 1'b0;
    endcase
  end

  // Commit path: register-file writes and the retire pulse are valid for the
  // single cycle after an accept. A memory destination suppresses the primary write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rfWrEn       <= 1'b0;
      rfWrAddr     <= '0;
      rfWrData     <= '0;
      rfWr2En      <= 1'b0;
      rfWr2Addr    <= '0;
      rfWr2Data    <= '0;
      retireOut    <= 1'b0;
      retireRipOut <= '0;
      store_done   <= 1'b0;
    end else begin
      rfWrEn    <= accept && destRegValidIn && !isMemoryAccessDestIn;
      rfWr2En   <= accept && destRegSpecialValidIn;
      retireOut <= accept;
      if (accept) begin
        rfWrAddr     <= destRegIn;
        rfWrData     <= destRegValueIn;
        rfWr2Addr    <= destRegSpecialIn;
        rfWr2Data    <= destRegSpecialValueIn;
        retireRipOut <= currentRipIn;
        store_done   <= 1'b0;
      end else if (state == ST_RESP && stRespCyc) begin
        // Completed store stays marked until the instruction is accepted,
        // even if validIn dropped meanwhile.
        store_done <= 1'b1;
      end
    end
  end

`ifdef WB_TRACE_EN
  logic [63:0]       retired_count;
  logic [7:0]        trace_op;
  logic [ADDR_W-1:0] trace_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count <= '0;
      trace_op      <= '0;
      trace_addr    <= '0;
    end else begin
      if (accept) trace_op <= opcodeIn;
      if (state == IDLE && store_start) trace_addr <= memoryAddressDestIn;
      if (retireOut) begin
        retired_count <= retired_count + 64'd1;
        $display("RETIRE n=%d rip=%x op=%x", retired_count + 64'd1, retireRipOut, trace_op);
      end
      if (state == ST_DATA && stReqAck)
        $display("STORE addr=%x data=%x", trace_addr, stReq);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage: reset, ALU commit, store handshake,
// dual register writes, reset during a store and back-to-back retires.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        validIn;
  logic [63:0] currentRipIn;
  logic [7:0]  opcodeIn;
  logic [3:0]  destRegIn;
  logic        destRegValidIn;
  logic [63:0] destRegValueIn;
  logic [3:0]  destRegSpecialIn;
  logic        destRegSpecialValidIn;
  logic [63:0] destRegSpecialValueIn;
  logic        isMemoryAccessDestIn;
  logic [63:0] memoryAddressDestIn;
  logic        wbStallOut;
  logic        rfWrEn;
  logic [3:0]  rfWrAddr;
  logic [63:0] rfWrData;
  logic        rfWr2En;
  logic [3:0]  rfWr2Addr;
  logic [63:0] rfWr2Data;
  logic        retireOut;
  logic [63:0] retireRipOut;
  logic        stReqCyc;
  logic [63:0] stReq;
  logic [9:0]  stReqTag;
  logic        stReqAck;
  logic        stRespCyc;
  logic        stRespAck;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .validIn               (validIn),
    .currentRipIn          (currentRipIn),
    .opcodeIn              (opcodeIn),
    .destRegIn             (destRegIn),
    .destRegValidIn        (destRegValidIn),
    .destRegValueIn        (destRegValueIn),
    .destRegSpecialIn      (destRegSpecialIn),
    .destRegSpecialValidIn (destRegSpecialValidIn),
    .destRegSpecialValueIn (destRegSpecialValueIn),
    .isMemoryAccessDestIn  (isMemoryAccessDestIn),
    .memoryAddressDestIn   (memoryAddressDestIn),
    .wbStallOut            (wbStallOut),
    .rfWrEn                (rfWrEn),
    .rfWrAddr              (rfWrAddr),
    .rfWrData              (rfWrData),
    .rfWr2En               (rfWr2En),
    .rfWr2Addr             (rfWr2Addr),
    .rfWr2Data             (rfWr2Data),
    .retireOut             (retireOut),
    .retireRipOut          (retireRipOut),
    .stReqCyc              (stReqCyc),
    .stReq                 (stReq),
    .stReqTag              (stReqTag),
    .stReqAck              (stReqAck),
    .stRespCyc             (stRespCyc),
    .stRespAck             (stRespAck)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_instr(input logic [63:0] rip, input logic [7:0] op,
                             input logic [3:0] rd, input logic rd_v, input logic [63:0] rd_val,
                             input logic [3:0] rs, input logic rs_v, input logic [63:0] rs_val,
                             input logic is_mem, input logic [63:0] addr);
    validIn               = 1'b1;
    currentRipIn          = rip;
    opcodeIn              = op;
    destRegIn             = rd;
    destRegValidIn        = rd_v;
    destRegValueIn        = rd_val;
    destRegSpecialIn      = rs;
    destRegSpecialValidIn = rs_v;
    destRegSpecialValueIn = rs_val;
    isMemoryAccessDestIn  = is_mem;
    memoryAddressDestIn   = addr;
  endtask

  initial begin
    reset = 1'b1;
    stReqAck = 1'b0;
    stRespCyc = 1'b0;
    drive_instr(64'h100, 8'h01, 4'd3, 1'b1, 64'hDEAD, 4'd0, 1'b0, 64'h0, 1'b0, 64'h0);

    // Reset held two cycles with a valid instruction present.
    repeat (2) begin
      step();
      check("rst_retire", retireOut, 0);
      check("rst_rfwren", rfWrEn, 0);
      check("rst_rfwr2en", rfWr2En, 0);
      check("rst_streqcyc", stReqCyc, 0);
      check("rst_stRespAck", stRespAck, 0);
      check("rst_rfwrdata", rfWrData, 0);
      check("rst_riprout", retireRipOut, 0);
      check("rst_streq", stReq, 0);
    end
    reset = 1'b0;
    #1 check("alu_stall", wbStallOut, 0);
    // IDLE ignores stReqAck.
    stReqAck = 1'b1;

    // ALU op accepted at the first edge after reset release.
    step();
    check("alu_retire", retireOut, 1);
    check("alu_rip", retireRipOut, 64'h100);
    check("alu_rfwren", rfWrEn, 1);
    check("alu_rfwraddr", rfWrAddr, 3);
    check("alu_rfwrdata", rfWrData, 64'hDEAD);
    check("alu_rfwr2en", rfWr2En, 0);
    check("alu_ack_ignored", stReqCyc, 0);
    stReqAck = 1'b0;
    validIn = 1'b0;
    step();
    check("alu_pulse_end", retireOut, 0);
    check("alu_rfwren_end", rfWrEn, 0);

    // Store: addr 0x1000, data 0x55, acks delayed, completion 3 cycles later.
    drive_instr(64'h200, 8'h89, 4'd5, 1'b1, 64'h55, 4'd0, 1'b0, 64'h0, 1'b1, 64'h1000);
    #1 check("st_stall_comb", wbStallOut, 1);
    step();                                   // ST_ADDR
    check("st_cyc_addr", stReqCyc, 1);
    check("st_beat_addr", stReq, 64'h1000);
    check("st_tag", stReqTag, 10'h389);
    check("st_no_retire0", retireOut, 0);
    stRespCyc = 1'b1;                         // completion outside ST_RESP: ignored
    step();
    stRespCyc = 1'b0;
    check("st_early_resp_ign", stRespAck, 0);
    check("st_hold_addr", stReq, 64'h1000);
    step();
    stReqAck = 1'b1;
    step();                                   // ST_DATA
    stReqAck = 1'b0;
    check("st_beat_data", stReq, 64'h55);
    check("st_cyc_data", stReqCyc, 1);
    check("st_stall_data", wbStallOut, 1);
    step();
    step();
    stReqAck = 1'b1;
    stRespCyc = 1'b1;                         // coincides with last ack: not sampled
    step();                                   // ST_RESP
    stReqAck = 1'b0;
    stRespCyc = 1'b0;
    check("st_cyc_low", stReqCyc, 0);
    check("st_same_cycle_resp", stRespAck, 0);
    check("st_stall_resp", wbStallOut, 1);
    check("st_no_retire1", retireOut, 0);
    step();
    step();
    stRespCyc = 1'b1;
    step();                                   // back to IDLE
    stRespCyc = 1'b0;
    check("st_resp_ack", stRespAck, 1);
    check("st_no_retire2", retireOut, 0);
    #1 check("st_stall_drop", wbStallOut, 0);
    step();                                   // store retires
    check("st_resp_ack_1cyc", stRespAck, 0);
    check("st_retire", retireOut, 1);
    check("st_retire_rip", retireRipOut, 64'h200);
    check("st_rfwren_supp", rfWrEn, 0);
    check("st_idle_cyc", stReqCyc, 0);
    validIn = 1'b0;
    step();
    check("st_single_retire", retireOut, 0);

    // MUL-style: both ports, then both ports on the same register.
    drive_instr(64'h300, 8'hF7, 4'd0, 1'b1, 64'd5, 4'd2, 1'b1, 64'd7, 1'b0, 64'h0);
    step();
    drive_instr(64'h308, 8'hF7, 4'd0, 1'b1, 64'd5, 4'd0, 1'b1, 64'd7, 1'b0, 64'h0);
    check("mul_rfwren", rfWrEn, 1);
    check("mul_rfwraddr", rfWrAddr, 0);
    check("mul_rfwrdata", rfWrData, 5);
    check("mul_rfwr2en", rfWr2En, 1);
    check("mul_rfwr2addr", rfWr2Addr, 2);
    check("mul_rfwr2data", rfWr2Data, 7);
    step();
    validIn = 1'b0;
    check("mul2_rfwren", rfWrEn, 1);
    check("mul2_rfwr2en", rfWr2En, 1);
    check("mul2_rfwr2addr", rfWr2Addr, 0);
    check("mul2_rfwr2data", rfWr2Data, 7);
    check("mul2_rip", retireRipOut, 64'h308);

    // Reset while in ST_DATA.
    drive_instr(64'h500, 8'h88, 4'd1, 1'b0, 64'h77, 4'd0, 1'b0, 64'h0, 1'b1, 64'h2000);
    step();                                   // ST_ADDR
    stReqAck = 1'b1;
    step();                                   // ST_DATA
    stReqAck = 1'b0;
    check("rsd_beat_data", stReq, 64'h77);
    check("rsd_cyc", stReqCyc, 1);
    reset = 1'b1;
    validIn = 1'b0;
    step();
    reset = 1'b0;
    check("rsd_cyc_low", stReqCyc, 0);
    check("rsd_retire", retireOut, 0);
    check("rsd_respack", stRespAck, 0);
    #1 check("rsd_stall", wbStallOut, 0);
    stRespCyc = 1'b1;
    step();
    stRespCyc = 1'b0;
    check("rsd_late_resp_ign", stRespAck, 0);
    check("rsd_no_retire", retireOut, 0);

    // Four back-to-back non-store instructions.
    for (int i = 0; i < 4; i++) begin
      drive_instr(64'h400 + 64'(i) * 64'h10, 8'h02, 4'(i + 4), 1'b1, 64'(i) + 64'hA0,
                  4'd0, 1'b0, 64'h0, 1'b0, 64'h0);
      #1 check($sformatf("b2b_stall%0d", i), wbStallOut, 0);
      step();
      check($sformatf("b2b_retire%0d", i), retireOut, 1);
      check($sformatf("b2b_rip%0d", i), retireRipOut, 64'h400 + 64'(i) * 64'h10);
      check($sformatf("b2b_data%0d", i), rfWrData, 64'(i) + 64'hA0);
    end
    validIn = 1'b0;
    step();
    check("b2b_end", retireOut, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
